// File: rtl/riscv_lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_lsu_pkg : access sizes, LSU states and lane helpers             |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [0:0] {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_t;

  // Unsigned load sizes share the lane layout of their signed twins.
  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] wd);
    case (size[1:0])
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic lsu_legal(input logic we, input logic [2:0] size,
                                     input logic [1:0] off);
    case (size)
      LDST_B:  return 1'b1;
      LDST_H:  return ~off[0];
      LDST_W:  return off == 2'b00;
      LDST_BU: return ~we;
      LDST_HU: return ~we & ~off[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_lsu_if : core-side and memory-side buses of the load/store unit |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        core_fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  // The LSU itself.
  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_req_o, core_fault_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  // Core plus memory environment around the LSU.
  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_req_o, core_fault_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface
`default_nettype wire

// File: rtl/riscv_lsu_load_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_lsu_load_ext : byte/halfword select and sign/zero extension     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module riscv_lsu_load_ext
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (size_i)
      LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data_o = {24'd0, byte_sel};
      LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_lsu : load/store unit between memory stage and data memory      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  riscv_lsu_if.slave  bus
);

  lsu_state_t  state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_data;

  riscv_lsu_load_ext u_load_ext (
    .word_i   (bus.mem_rd_i),
    .size_i   (size_q),
    .offset_i (off_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LSU_IDLE;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    size_d               = size_q;
    off_d                = off_q;
    bus.core_rd_o        = 32'd0;
    bus.core_stall_req_o = 1'b0;
    bus.core_fault_o     = 1'b0;
    bus.mem_req_o        = 1'b0;
    bus.mem_we_o         = 1'b0;
    bus.mem_be_o         = 4'd0;
    bus.mem_addr_o       = 32'd0;
    bus.mem_wd_o         = 32'd0;

    case (state_q)
      LSU_IDLE: begin
        if (bus.core_req_i) begin
          if (lsu_legal(bus.core_we_i, bus.core_size_i, bus.core_addr_i[1:0])) begin
            bus.mem_req_o        = 1'b1;
            bus.mem_we_o         = bus.core_we_i;
            bus.mem_be_o         = lsu_be(bus.core_size_i, bus.core_addr_i[1:0]);
            bus.mem_addr_o       = {bus.core_addr_i[31:2], 2'b00};
            bus.mem_wd_o         = lsu_wdata(bus.core_size_i, bus.core_wd_i);
            bus.core_stall_req_o = 1'b1;
            size_d               = bus.core_size_i;
            off_d                = bus.core_addr_i[1:0];
            state_d              = LSU_WAIT;
          end else begin
            bus.core_fault_o = 1'b1;
          end
        end
      end
      default: begin
        // Core holds its request stable while stalled, so address and data
        // come straight from the core; lane layout comes from the capture.
        bus.mem_req_o        = 1'b1;
        bus.mem_we_o         = bus.core_we_i;
        bus.mem_be_o         = lsu_be(size_q, off_q);
        bus.mem_addr_o       = {bus.core_addr_i[31:2], 2'b00};
        bus.mem_wd_o         = lsu_wdata(size_q, bus.core_wd_i);
        bus.core_stall_req_o = ~bus.mem_ready_i;
        if (bus.mem_ready_i) begin
          state_d = LSU_IDLE;
          if (!bus.core_we_i) begin
            bus.core_rd_o = load_data;
          end
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_riscv_lsu : directed vector bench for the load/store unit          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_riscv_lsu;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  riscv_lsu_if bus ();

  riscv_lsu u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] mrd, input logic fault,
                              input logic [3:0] be, input logic [31:0] mwd, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.mrd = mrd;
    v.fault = fault; v.be = be; v.mwd = mwd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs sampled 3ns after it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd0;
    bus.core_addr_i = 32'd0;
    bus.core_wd_i   = 32'd0;
    bus.mem_rd_i    = 32'd0;
    bus.mem_ready_i = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},   {31'd0, bus.mem_req_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, bus.core_stall_req_o}, 32'd0);
    chk({tag, "_fault"}, {31'd0, bus.core_fault_o}, 32'd0);
    chk({tag, "_rd"},    bus.core_rd_o, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive_idle();
    rst = 1'b1;

    vecs[0]  = mk(1'b1, 3'd0, 32'h0000_1002, 32'h0000_00A5, 32'h0, 1'b0, 4'b0100, 32'hA5A5_A5A5, 32'h0);
    vecs[1]  = mk(1'b0, 3'd0, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 1'b0, 4'b0100, 32'h0, 32'hFFFF_FFFF);
    vecs[2]  = mk(1'b0, 3'd4, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 1'b0, 4'b0100, 32'h0, 32'h0000_00FF);
    vecs[3]  = mk(1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80);
    vecs[4]  = mk(1'b0, 3'd1, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 1'b0, 4'b1100, 32'h0, 32'hFFFF_80FF);
    vecs[5]  = mk(1'b0, 3'd5, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 1'b0, 4'b1100, 32'h0, 32'h0000_80FF);
    vecs[6]  = mk(1'b1, 3'd1, 32'h0000_1002, 32'h0000_1234, 32'h0, 1'b0, 4'b1100, 32'h1234_1234, 32'h0);
    vecs[7]  = mk(1'b0, 3'd2, 32'h0000_1001, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    vecs[8]  = mk(1'b1, 3'd1, 32'h0000_1003, 32'h0000_1234, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    vecs[9]  = mk(1'b0, 3'd3, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    vecs[10] = mk(1'b0, 3'd0, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 1'b0, 4'b0001, 32'h0, 32'h0000_0001);
    vecs[11] = mk(1'b0, 3'd1, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 1'b0, 4'b0011, 32'h0, 32'h0000_7F01);
    vecs[12] = mk(1'b1, 3'd2, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vecs[13] = mk(1'b1, 3'd4, 32'h0000_2000, 32'h0000_0011, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    vecs[14] = mk(1'b0, 3'd5, 32'h0000_1001, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
    vecs[15] = mk(1'b0, 3'd0, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 1'b0, 4'b0010, 32'h0, 32'h0000_007F);
    vecs[16] = mk(1'b0, 3'd2, 32'h0000_1004, 32'h0, 32'h80FF_7F01, 1'b0, 4'b1111, 32'h0, 32'h80FF_7F01);

    // Reset state, including memory ready being ignored while idle.
    next_cycle();
    next_cycle();
    rst = 1'b0;
    bus.mem_ready_i = 1'b1;
    bus.mem_rd_i    = 32'h1234_5678;
    settle();
    chk_quiet("reset_idle");
    next_cycle();
    drive_idle();

    for (int i = 0; i < NVEC; i++) begin
      bus.core_req_i  = 1'b1;
      bus.core_we_i   = vecs[i].we;
      bus.core_size_i = vecs[i].size;
      bus.core_addr_i = vecs[i].addr;
      bus.core_wd_i   = vecs[i].wd;
      settle();
      chk($sformatf("v%0d_fault", i), {31'd0, bus.core_fault_o}, {31'd0, vecs[i].fault});
      chk($sformatf("v%0d_req", i), {31'd0, bus.mem_req_o}, {31'd0, ~vecs[i].fault});
      chk($sformatf("v%0d_stall", i), {31'd0, bus.core_stall_req_o}, {31'd0, ~vecs[i].fault});
      if (!vecs[i].fault) begin
        chk($sformatf("v%0d_we", i), {31'd0, bus.mem_we_o}, {31'd0, vecs[i].we});
        chk($sformatf("v%0d_be", i), {28'd0, bus.mem_be_o}, {28'd0, vecs[i].be});
        chk($sformatf("v%0d_addr", i), bus.mem_addr_o, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_wd", i), bus.mem_wd_o, vecs[i].mwd);
        next_cycle();
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = vecs[i].mrd;
        settle();
        chk($sformatf("v%0d_done_stall", i), {31'd0, bus.core_stall_req_o}, 32'd0);
        chk($sformatf("v%0d_done_req", i), {31'd0, bus.mem_req_o}, 32'd1);
        chk($sformatf("v%0d_done_be", i), {28'd0, bus.mem_be_o}, {28'd0, vecs[i].be});
        chk($sformatf("v%0d_rd", i), bus.core_rd_o, vecs[i].rd);
      end
      next_cycle();
      drive_idle();
      settle();
      chk_quiet($sformatf("v%0d_after", i));
      next_cycle();
    end

    // LW with three wait states: four stall cycles, data only when ready.
    bus.core_req_i  = 1'b1;
    bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h0000_3000;
    bus.mem_rd_i    = 32'hCAFE_F00D;
    settle();
    chk("ws_accept_stall", {31'd0, bus.core_stall_req_o}, 32'd1);
    for (int w = 0; w < 3; w++) begin
      next_cycle();
      settle();
      chk($sformatf("ws%0d_stall", w), {31'd0, bus.core_stall_req_o}, 32'd1);
      chk($sformatf("ws%0d_req", w), {31'd0, bus.mem_req_o}, 32'd1);
      chk($sformatf("ws%0d_rd", w), bus.core_rd_o, 32'd0);
    end
    next_cycle();
    bus.mem_ready_i = 1'b1;
    settle();
    chk("ws_done_stall", {31'd0, bus.core_stall_req_o}, 32'd0);
    chk("ws_done_req", {31'd0, bus.mem_req_o}, 32'd1);
    chk("ws_done_rd", bus.core_rd_o, 32'hCAFE_F00D);
    next_cycle();
    drive_idle();
    settle();
    chk_quiet("ws_after");
    next_cycle();

    // Reset while waiting drops the access.
    bus.core_req_i  = 1'b1;
    bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h0000_3004;
    settle();
    chk("rw_accept_req", {31'd0, bus.mem_req_o}, 32'd1);
    next_cycle();
    settle();
    chk("rw_wait_stall", {31'd0, bus.core_stall_req_o}, 32'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive_idle();
    settle();
    chk_quiet("rw_after_reset");
    next_cycle();
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b1;
    bus.core_size_i = 3'd2;
    bus.core_addr_i = 32'h0000_4000;
    bus.core_wd_i   = 32'h0BAD_F00D;
    settle();
    chk("rw_sw_req", {31'd0, bus.mem_req_o}, 32'd1);
    chk("rw_sw_be", {28'd0, bus.mem_be_o}, 32'h0000_000F);
    chk("rw_sw_wd", bus.mem_wd_o, 32'h0BAD_F00D);
    next_cycle();
    bus.mem_ready_i = 1'b1;
    settle();
    chk("rw_sw_done_stall", {31'd0, bus.core_stall_req_o}, 32'd0);
    chk("rw_sw_done_we", {31'd0, bus.mem_we_o}, 32'd1);
    next_cycle();
    drive_idle();
    settle();
    chk_quiet("rw_sw_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
